// File: rtl/turnstile_pkg.sv
// Shared turnstile definitions: FSM state encoding and lock-level
// constants used by both the fare collector and the turnstile end.
package turnstile_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    COLLECT     = 3'd1,
    GRANT       = 3'd2,
    WAIT_UNLOCK = 3'd3,
    WAIT_RELOCK = 3'd4,
    REFUND      = 3'd5
  } state_t;

  localparam logic LOCKED   = 1'b1;
  localparam logic UNLOCKED = 1'b0;

endpackage

// File: rtl/timeout_timer.sv
// Idle-cycle timer: cleared on restart, flags expiry in the
// TIMEOUT-th cycle after the last restart and then holds there.
module timeout_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_restart) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_expired = (cnt == LAST);

endmodule

// File: rtl/fare_collector.sv
// Coin-operated turnstile fare collector with refund and fault handling.
// Define FARE_COLLECTOR_STATS_EN to build the pass/refund counters.
module fare_collector
  import turnstile_pkg::*;
#(
  parameter int FARE     = 4,
  parameter int CREDIT_W = 4,
  parameter int TIMEOUT  = 1000,
  parameter int COUNT_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_coin_valid,
  input  logic [CREDIT_W-1:0] i_coin_value,
  input  logic                i_locked,
  output logic                o_coin,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_refund_valid,
  output logic [CREDIT_W-1:0] o_refund_value,
  output logic                o_fault,
  output logic [COUNT_W-1:0]  o_pass_count,
  output logic [COUNT_W-1:0]  o_refund_count
);

  localparam logic [CREDIT_W-1:0] FARE_C = CREDIT_W'(FARE);
  localparam logic [CREDIT_W-1:0] CMAX   = '1;

  function automatic logic [CREDIT_W-1:0] sat_add(
    input logic [CREDIT_W-1:0] a,
    input logic [CREDIT_W-1:0] b
  );
    logic [CREDIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CREDIT_W] ? CMAX : s[CREDIT_W-1:0];
  endfunction

  state_t state, state_nx;

  logic [CREDIT_W-1:0] credit, credit_nx;
  logic [CREDIT_W-1:0] coin_in, credit_add;
  logic                coin_q, coin_nx;
  logic                fault, fault_nx;
  logic                coin_take;
  logic                restart;
  logic                expired;

  assign coin_in    = i_coin_valid ? i_coin_value : '0;
  assign coin_take  = i_coin_valid && (state != REFUND);
  assign credit_add = sat_add(credit, coin_in);

  always_comb begin
    state_nx  = state;
    credit_nx = credit_add;
    coin_nx   = 1'b0;
    fault_nx  = fault;
    unique case (state)
      IDLE: begin
        if (coin_take && (i_coin_value != '0)) begin
          state_nx = COLLECT;
        end
      end
      COLLECT: begin
        if (credit_add >= FARE_C) begin
          state_nx = GRANT;
        end else if (expired && !coin_take) begin
          state_nx = REFUND;
        end
      end
      GRANT: begin
        // credit >= FARE is guaranteed on entry to GRANT
        credit_nx = sat_add(credit - FARE_C, coin_in);
        coin_nx   = 1'b1;
        state_nx  = WAIT_UNLOCK;
      end
      WAIT_UNLOCK: begin
        if (i_locked == UNLOCKED) begin
          state_nx = WAIT_RELOCK;
        end else if (expired && !coin_take) begin
          fault_nx  = 1'b1;
          credit_nx = sat_add(credit_add, FARE_C);
          state_nx  = REFUND;
        end
      end
      WAIT_RELOCK: begin
        if (i_locked == LOCKED) begin
          if (credit_add >= FARE_C) begin
            state_nx = GRANT;
          end else if (credit_add != '0) begin
            state_nx = COLLECT;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      REFUND: begin
        // credit is paid out this cycle; a coin lands on the cleared value
        credit_nx = coin_in;
        state_nx  = IDLE;
      end
      default: begin
        state_nx  = IDLE;
        credit_nx = '0;
      end
    endcase
  end

  assign restart = (state_nx != state) || coin_take;

  timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_restart (restart),
    .o_expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      credit <= '0;
      coin_q <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_nx;
      credit <= credit_nx;
      coin_q <= coin_nx;
      fault  <= fault_nx;
    end
  end

  assign o_coin         = coin_q;
  assign o_credit       = credit;
  assign o_fault        = fault;
  assign o_refund_valid = (state == REFUND);
  assign o_refund_value = (state == REFUND) ? credit : '0;

`ifdef FARE_COLLECTOR_STATS_EN
  logic [COUNT_W-1:0] pass_cnt;
  logic [COUNT_W-1:0] refund_cnt;
  logic               pass_inc;
  logic               refund_inc;

  assign pass_inc   = (state == WAIT_RELOCK) && (i_locked == LOCKED);
  assign refund_inc = (state == REFUND);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pass_cnt   <= '0;
      refund_cnt <= '0;
    end else begin
      if (pass_inc) begin
        pass_cnt <= pass_cnt + 1'b1;
      end
      if (refund_inc) begin
        refund_cnt <= refund_cnt + 1'b1;
      end
    end
  end

  assign o_pass_count   = pass_cnt;
  assign o_refund_count = refund_cnt;
`else
  assign o_pass_count   = '0;
  assign o_refund_count = '0;
`endif

endmodule

// File: tb/tb_fare_collector.sv
// Directed self-checking bench for fare_collector
// (FARE=4, CREDIT_W=4, TIMEOUT=8).
module tb_fare_collector;
  import turnstile_pkg::*;

  localparam int FARE = 4;
  localparam int CW   = 4;
  localparam int TO   = 8;
  localparam int NW   = 16;
`ifdef FARE_COLLECTOR_STATS_EN
  localparam int ST = 1;
`else
  localparam int ST = 0;
`endif

  logic          i_clk;
  logic          i_reset;
  logic          i_coin_valid;
  logic [CW-1:0] i_coin_value;
  logic          i_locked;
  logic          o_coin;
  logic [CW-1:0] o_credit;
  logic          o_refund_valid;
  logic [CW-1:0] o_refund_value;
  logic          o_fault;
  logic [NW-1:0] o_pass_count;
  logic [NW-1:0] o_refund_count;

  int n_run  = 0;
  int n_fail = 0;

  fare_collector #(
    .FARE     (FARE),
    .CREDIT_W (CW),
    .TIMEOUT  (TO),
    .COUNT_W  (NW)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_coin_valid   (i_coin_valid),
    .i_coin_value   (i_coin_value),
    .i_locked       (i_locked),
    .o_coin         (o_coin),
    .o_credit       (o_credit),
    .o_refund_valid (o_refund_valid),
    .o_refund_value (o_refund_value),
    .o_fault        (o_fault),
    .o_pass_count   (o_pass_count),
    .o_refund_count (o_refund_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    chk(tag, 32'(dut.state), 32'(exp));
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic coin(input logic [CW-1:0] v);
    i_coin_valid = 1'b1;
    i_coin_value = v;
    tick();
    i_coin_valid = 1'b0;
    i_coin_value = '0;
  endtask

  task automatic pass_turnstile();
    i_locked = UNLOCKED;
    tick();
    i_locked = LOCKED;
    tick();
  endtask

  initial begin
    i_reset      = 1'b1;
    i_coin_valid = 1'b0;
    i_coin_value = '0;
    i_locked     = LOCKED;

    tick();
    chk_st("rst_state", IDLE);
    chk("rst_credit", 32'(o_credit), 0);
    chk("rst_coin", 32'(o_coin), 0);
    chk("rst_rv", 32'(o_refund_valid), 0);
    chk("rst_rval", 32'(o_refund_value), 0);
    chk("rst_fault", 32'(o_fault), 0);
    chk("rst_pc", 32'(o_pass_count), 0);
    chk("rst_rc", 32'(o_refund_count), 0);
    i_reset = 1'b0;

    coin(4'd0);
    chk_st("zero_coin_idle", IDLE);
    chk("zero_coin_credit", 32'(o_credit), 0);

    // coins 2,2 -> pass
    coin(4'd2);
    chk_st("c2_collect", COLLECT);
    chk("c2_credit", 32'(o_credit), 2);
    coin(4'd2);
    chk_st("c4_grant", GRANT);
    chk("c4_no_coin_yet", 32'(o_coin), 0);
    chk("c4_credit", 32'(o_credit), 4);
    tick();
    chk("p1_coin", 32'(o_coin), 1);
    chk("p1_credit", 32'(o_credit), 0);
    chk_st("p1_wu", WAIT_UNLOCK);
    i_locked = UNLOCKED;
    tick();
    chk("p1_coin_pulse", 32'(o_coin), 0);
    chk_st("p1_wr", WAIT_RELOCK);
    tick();
    chk_st("p1_wr_hold", WAIT_RELOCK);
    i_locked = LOCKED;
    tick();
    chk_st("p1_idle", IDLE);
    chk("p1_credit_end", 32'(o_credit), 0);
    chk("p1_pc", 32'(o_pass_count), 32'(ST * 1));

    // coin 9 -> two passes, leftover 1 times out into refund
    coin(4'd9);
    chk_st("c9_collect", COLLECT);
    tick();
    chk_st("c9_grant", GRANT);
    tick();
    chk("c9_coin1", 32'(o_coin), 1);
    chk("c9_credit5", 32'(o_credit), 5);
    pass_turnstile();
    chk_st("c9_regrant", GRANT);
    chk("c9_pc2", 32'(o_pass_count), 32'(ST * 2));
    tick();
    chk("c9_coin2", 32'(o_coin), 1);
    chk("c9_credit1", 32'(o_credit), 1);
    pass_turnstile();
    chk_st("c9_collect1", COLLECT);
    chk("c9_pc3", 32'(o_pass_count), 32'(ST * 3));
    ticks(TO - 1);
    chk_st("to_still_collect", COLLECT);
    chk("to_no_refund", 32'(o_refund_valid), 0);
    tick();
    chk_st("to_refund", REFUND);
    chk("to_rv", 32'(o_refund_valid), 1);
    chk("to_rval", 32'(o_refund_value), 1);
    tick();
    chk_st("to_idle", IDLE);
    chk("to_rv_off", 32'(o_refund_valid), 0);
    chk("to_credit0", 32'(o_credit), 0);
    chk("to_rc1", 32'(o_refund_count), 32'(ST * 1));

    // turnstile never unlocks -> fault and refund of the fare
    coin(4'd4);
    tick();
    tick();
    chk("f_coin", 32'(o_coin), 1);
    chk("f_credit0", 32'(o_credit), 0);
    ticks(TO - 1);
    chk_st("f_still_wu", WAIT_UNLOCK);
    chk("f_no_fault", 32'(o_fault), 0);
    tick();
    chk("f_fault", 32'(o_fault), 1);
    chk("f_rv", 32'(o_refund_valid), 1);
    chk("f_rval", 32'(o_refund_value), 4);
    tick();
    chk("f_credit_end", 32'(o_credit), 0);
    chk("f_fault_sticky", 32'(o_fault), 1);
    chk("f_rc2", 32'(o_refund_count), 32'(ST * 2));
    chk("f_pc3", 32'(o_pass_count), 32'(ST * 3));

    // saturation, and a coin during GRANT
    coin(4'd15);
    chk("s_credit15", 32'(o_credit), 15);
    coin(4'd3);
    chk("s_sat15", 32'(o_credit), 15);
    chk_st("s_grant", GRANT);
    coin(4'd2);
    chk("s_credit13", 32'(o_credit), 13);
    chk("s_coin", 32'(o_coin), 1);
    chk("s_fault_sticky", 32'(o_fault), 1);

    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("r1_fault_clr", 32'(o_fault), 0);
    chk("r1_credit", 32'(o_credit), 0);
    chk_st("r1_idle", IDLE);

    // reset in WAIT_RELOCK with credit 3
    coin(4'd7);
    tick();
    tick();
    chk("w_credit3", 32'(o_credit), 3);
    i_locked = UNLOCKED;
    tick();
    chk_st("w_wr", WAIT_RELOCK);
    i_reset = 1'b1;
    tick();
    i_reset  = 1'b0;
    i_locked = LOCKED;
    chk_st("r2_idle", IDLE);
    chk("r2_credit", 32'(o_credit), 0);
    chk("r2_coin", 32'(o_coin), 0);
    chk("r2_rv", 32'(o_refund_valid), 0);
    chk("r2_rval", 32'(o_refund_value), 0);
    chk("r2_pc", 32'(o_pass_count), 0);
    chk("r2_rc", 32'(o_refund_count), 0);
    tick();
    chk("r2_no_refund", 32'(o_refund_valid), 0);
    chk_st("r2_idle_hold", IDLE);
    chk("r2_pc_hold", 32'(o_pass_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
